// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes RV64 base ALU, branch and Zba ops into the
// execute-stage ALU controls behind a valid/ready ID/EX register.
package alu_issue_pkg;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_AND    = 4'b0010;
  localparam logic [3:0] ALU_OR     = 4'b0011;
  localparam logic [3:0] ALU_SLT    = 4'b0100;
  localparam logic [3:0] ALU_XOR    = 4'b0101;
  localparam logic [3:0] ALU_SH1ADD = 4'b1000;
  localparam logic [3:0] ALU_SH2ADD = 4'b1001;
  localparam logic [3:0] ALU_SH3ADD = 4'b1010;
  localparam logic [3:0] ALU_ADDUW  = 4'b1011;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [63:0] srcA;
    logic [63:0] srcB;
    logic [3:0]  aluCtl;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        regWrite;
    logic        branch;
    logic        illegal;
  } id_ex_t;

endpackage

module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      InstrD,
  input  logic [63:0]      RD1D,
  input  logic [63:0]      RD2D,
  input  logic             ValidD,
  output logic             ReadyD,
  input  logic             FlushE,
  output logic             ValidE,
  input  logic             ReadyE,
  output logic [63:0]      SrcAE,
  output logic [63:0]      SrcBE,
  output logic [3:0]       ALUControlE,
  output logic [2:0]       funct3E,
  output logic [4:0]       RdE,
  output logic             RegWriteE,
  output logic             BranchE,
  output logic             IllegalE,
  output logic [CNT_W-1:0] ZbaCountE
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       isOp;
  logic       isOp32;
  logic       isImm;
  logic       isBr;
  logic       legal;
  logic [3:0] aluSel;
  logic       isZba;
  logic       accept;
  id_ex_t     dec;
  id_ex_t     exReg;
  logic       validReg;
  logic [CNT_W-1:0] zbaCnt;

  assign opcode = InstrD[6:0];
  assign f3     = InstrD[14:12];
  assign f7     = InstrD[31:25];
  assign isOp   = (opcode == OPC_OP);
  assign isOp32 = (opcode == OPC_OP32);
  assign isImm  = (opcode == OPC_OPIMM);
  assign isBr   = (opcode == OPC_BRANCH);

  // Select ALU code and legality from opcode/funct fields
  always_comb begin
    legal  = 1'b0;
    aluSel = ALU_ADD;
    unique case (1'b1)
      isOp: begin
        unique case ({f7, f3})
          {7'h00, 3'b000}: begin legal = 1'b1; aluSel = ALU_ADD;    end
          {7'h00, 3'b010}: begin legal = 1'b1; aluSel = ALU_SLT;    end
          {7'h00, 3'b100}: begin legal = 1'b1; aluSel = ALU_XOR;    end
          {7'h00, 3'b110}: begin legal = 1'b1; aluSel = ALU_OR;     end
          {7'h00, 3'b111}: begin legal = 1'b1; aluSel = ALU_AND;    end
          {7'h20, 3'b000}: begin legal = 1'b1; aluSel = ALU_SUB;    end
          {7'h10, 3'b010}: begin legal = 1'b1; aluSel = ALU_SH1ADD; end
          {7'h10, 3'b100}: begin legal = 1'b1; aluSel = ALU_SH2ADD; end
          {7'h10, 3'b110}: begin legal = 1'b1; aluSel = ALU_SH3ADD; end
          default: ;
        endcase
      end
      isOp32: begin
        if ({f7, f3} == {7'h04, 3'b000}) begin
          legal  = 1'b1;
          aluSel = ALU_ADDUW;
        end
      end
      isImm: begin
        unique case (f3)
          3'b000: begin legal = 1'b1; aluSel = ALU_ADD; end
          3'b010: begin legal = 1'b1; aluSel = ALU_SLT; end
          3'b100: begin legal = 1'b1; aluSel = ALU_XOR; end
          3'b110: begin legal = 1'b1; aluSel = ALU_OR;  end
          3'b111: begin legal = 1'b1; aluSel = ALU_AND; end
          default: ;
        endcase
      end
      isBr: begin
        unique case (f3)
          3'b000, 3'b001, 3'b100, 3'b101: begin
            legal  = 1'b1;
            aluSel = ALU_SUB;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Build the ID/EX payload; illegal ops keep reg-reg operands
  always_comb begin
    dec          = '0;
    dec.srcA     = RD1D;
    dec.srcB     = (legal && isImm) ?
                   {{52{InstrD[31]}}, InstrD[31:20]} : RD2D;
    dec.aluCtl   = aluSel;
    dec.funct3   = (legal && isBr) ? f3 : 3'b010;
    dec.rd       = InstrD[11:7];
    dec.regWrite = legal && !isBr;
    dec.branch   = legal && isBr;
    dec.illegal  = !legal;
  end

  assign isZba  = legal && aluSel[3];
  assign ReadyD = !validReg || ReadyE;
  assign accept = ValidD && ReadyD && !FlushE;

  // Valid bit: flush wins, then accept, then drain on ReadyE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validReg <= 1'b0;
    end else if (FlushE) begin
      validReg <= 1'b0;
    end else if (accept) begin
      validReg <= 1'b1;
    end else if (ReadyE) begin
      validReg <= 1'b0;
    end
  end

  // Payload only moves on accept so stalls and drains hold it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exReg        <= '0;
      exReg.funct3 <= 3'b010;
    end else if (accept) begin
      exReg <= dec;
    end
  end

  // Saturating count of accepted Zba ops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zbaCnt <= '0;
    end else if (accept && isZba && (zbaCnt != '1)) begin
      zbaCnt <= zbaCnt + 1'b1;
    end
  end

  assign ValidE      = validReg;
  assign SrcAE       = exReg.srcA;
  assign SrcBE       = exReg.srcB;
  assign ALUControlE = exReg.aluCtl;
  assign funct3E     = exReg.funct3;
  assign RdE         = exReg.rd;
  assign RegWriteE   = exReg.regWrite;
  assign BranchE     = exReg.branch;
  assign IllegalE    = exReg.illegal;
  assign ZbaCountE   = zbaCnt;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: vector table through a scoreboard queue,
// plus stall/flush, reset-mid-stall and counter saturation sequences.
module tb_alu_issue_stage;

  localparam int CW = 4;
  localparam logic [6:0] OP  = 7'b0110011;
  localparam logic [6:0] O32 = 7'b0111011;
  localparam logic [6:0] BR  = 7'b1100011;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   InstrD = '0;
  logic [63:0]   RD1D = '0;
  logic [63:0]   RD2D = '0;
  logic          ValidD = 1'b0;
  logic          ReadyD;
  logic          FlushE = 1'b0;
  logic          ValidE;
  logic          ReadyE = 1'b1;
  logic [63:0]   SrcAE;
  logic [63:0]   SrcBE;
  logic [3:0]    ALUControlE;
  logic [2:0]    funct3E;
  logic [4:0]    RdE;
  logic          RegWriteE;
  logic          BranchE;
  logic          IllegalE;
  logic [CW-1:0] ZbaCountE;

  alu_issue_stage #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .InstrD(InstrD),
    .RD1D(RD1D), .RD2D(RD2D), .ValidD(ValidD),
    .ReadyD(ReadyD), .FlushE(FlushE), .ValidE(ValidE),
    .ReadyE(ReadyE), .SrcAE(SrcAE), .SrcBE(SrcBE),
    .ALUControlE(ALUControlE), .funct3E(funct3E),
    .RdE(RdE), .RegWriteE(RegWriteE), .BranchE(BranchE),
    .IllegalE(IllegalE), .ZbaCountE(ZbaCountE)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [63:0] expB;
    logic [3:0]  alu;
    logic [2:0]  f3;
    logic        rw;
    logic        br;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [63:0]   a;
    logic [63:0]   b;
    logic [3:0]    alu;
    logic [2:0]    f3;
    logic [4:0]    rd;
    logic          rw;
    logic          br;
    logic          ill;
    logic [CW-1:0] cnt;
  } exp_t;

  localparam int NV = 21;
  vec_t vecs[NV];
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [CW-1:0] cntModel = '0;

  function automatic logic [31:0] rI(input logic [6:0] f7,
    input logic [2:0] f3, input logic [4:0] rd,
    input logic [6:0] op);
    return {f7, 5'd7, 5'd6, f3, rd, op};
  endfunction

  function automatic logic [31:0] iI(input logic [11:0] imm,
    input logic [2:0] f3, input logic [4:0] rd);
    return {imm, 5'd2, f3, rd, 7'b0010011};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
    input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    exp_t e;
    InstrD = v.instr;
    RD1D   = v.rd1;
    RD2D   = v.rd2;
    ValidD = 1'b1;
    if (!v.ill && v.alu[3] && cntModel != '1)
      cntModel = cntModel + 1'b1;
    e.a   = v.rd1;
    e.b   = v.expB;
    e.alu = v.alu;
    e.f3  = v.f3;
    e.rd  = v.instr[11:7];
    e.rw  = v.rw;
    e.br  = v.br;
    e.ill = v.ill;
    e.cnt = cntModel;
    q.push_back(e);
  endtask

  task automatic popCheck();
    exp_t e;
    if (q.size() == 0) begin
      chk("sbEmpty", 64'd1, 64'd0);
      return;
    end
    e = q.pop_front();
    chk("ValidE", 64'(ValidE), 64'd1);
    chk("SrcAE", SrcAE, e.a);
    chk("SrcBE", SrcBE, e.b);
    chk("ALUControlE", 64'(ALUControlE), 64'(e.alu));
    chk("funct3E", 64'(funct3E), 64'(e.f3));
    chk("RdE", 64'(RdE), 64'(e.rd));
    chk("RegWriteE", 64'(RegWriteE), 64'(e.rw));
    chk("BranchE", 64'(BranchE), 64'(e.br));
    chk("IllegalE", 64'(IllegalE), 64'(e.ill));
    chk("ZbaCountE", 64'(ZbaCountE), 64'(e.cnt));
  endtask

  task automatic checkReset(input string tag);
    chk({tag, ".ValidE"}, 64'(ValidE), 64'd0);
    chk({tag, ".ReadyD"}, 64'(ReadyD), 64'd1);
    chk({tag, ".SrcAE"}, SrcAE, 64'd0);
    chk({tag, ".SrcBE"}, SrcBE, 64'd0);
    chk({tag, ".ALU"}, 64'(ALUControlE), 64'd0);
    chk({tag, ".funct3E"}, 64'(funct3E), 64'd2);
    chk({tag, ".RdE"}, 64'(RdE), 64'd0);
    chk({tag, ".RegWriteE"}, 64'(RegWriteE), 64'd0);
    chk({tag, ".BranchE"}, 64'(BranchE), 64'd0);
    chk({tag, ".IllegalE"}, 64'(IllegalE), 64'd0);
    chk({tag, ".ZbaCountE"}, 64'(ZbaCountE), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t sh1;
    vec_t xr;
    vec_t ad;

    vecs[0]  = '{rI(7'h10, 3'b100, 5'd5, OP), 64'h10, 64'h3,
                 64'h3, 4'b1001, 3'b010, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{rI(7'h04, 3'b000, 5'd8, O32),
                 64'hFFFF_FFFF_0000_0005, 64'h10, 64'h10,
                 4'b1011, 3'b010, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{iI(12'hFFF, 3'b000, 5'd1), 64'h20, 64'h55,
                 64'hFFFF_FFFF_FFFF_FFFF, 4'b0000, 3'b010,
                 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{{7'h0, 5'd4, 5'd3, 3'b101, 5'd0, BR},
                 64'h7, 64'h9, 64'h9, 4'b0001, 3'b101,
                 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{rI(7'h00, 3'b011, 5'd3, OP), 64'h11, 64'h22,
                 64'h22, 4'b0000, 3'b010, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{rI(7'h20, 3'b000, 5'd10, OP), 64'hA0, 64'h0B,
                 64'h0B, 4'b0001, 3'b010, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{rI(7'h00, 3'b111, 5'd11, OP), 64'hF0F0, 64'hFF,
                 64'hFF, 4'b0010, 3'b010, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{rI(7'h00, 3'b110, 5'd12, OP), 64'h1, 64'h2,
                 64'h2, 4'b0011, 3'b010, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{rI(7'h00, 3'b010, 5'd14, OP),
                 64'h8000_0000_0000_0000, 64'h1, 64'h1,
                 4'b0100, 3'b010, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{rI(7'h00, 3'b100, 5'd15, OP), 64'h1234, 64'h4321,
                 64'h4321, 4'b0101, 3'b010, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{rI(7'h10, 3'b010, 5'd16, OP), 64'h5, 64'h6,
                 64'h6, 4'b1000, 3'b010, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{rI(7'h10, 3'b110, 5'd17, OP), 64'h7, 64'h8,
                 64'h8, 4'b1010, 3'b010, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{iI(12'h123, 3'b100, 5'd13), 64'h99, 64'hAA,
                 64'h123, 4'b0101, 3'b010, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{iI(12'h800, 3'b010, 5'd18), 64'h3, 64'hBB,
                 64'hFFFF_FFFF_FFFF_F800, 4'b0100, 3'b010,
                 1'b1, 1'b0, 1'b0};
    vecs[14] = '{iI(12'h7FF, 3'b111, 5'd19), 64'hFFFF, 64'hCC,
                 64'h7FF, 4'b0010, 3'b010, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{iI(12'h0F0, 3'b110, 5'd20), 64'h0F, 64'hDD,
                 64'h0F0, 4'b0011, 3'b010, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{rI(7'h00, 3'b001, 5'd21, OP), 64'h31, 64'h32,
                 64'h32, 4'b0000, 3'b010, 1'b0, 1'b0, 1'b1};
    vecs[17] = '{{7'h0, 5'd2, 5'd1, 3'b000, 5'd0, BR},
                 64'h41, 64'h41, 64'h41, 4'b0001, 3'b000,
                 1'b0, 1'b1, 1'b0};
    vecs[18] = '{rI(7'h20, 3'b001, 5'd22, OP), 64'h51, 64'h52,
                 64'h52, 4'b0000, 3'b010, 1'b0, 1'b0, 1'b1};
    vecs[19] = '{rI(7'h04, 3'b001, 5'd23, O32), 64'h61, 64'h62,
                 64'h62, 4'b0000, 3'b010, 1'b0, 1'b0, 1'b1};
    vecs[20] = '{{7'h0, 5'd2, 5'd1, 3'b110, 5'd0, BR},
                 64'h71, 64'h72, 64'h72, 4'b0000, 3'b010,
                 1'b0, 1'b0, 1'b1};

    // Reset values while held in reset
    #12;
    checkReset("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Table: back-to-back issue with ReadyE high
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      if (q.size() != 0) popCheck();
      drive(vecs[i]);
    end
    @(negedge clk);
    ValidD = 1'b0;
    popCheck();
    @(negedge clk);
    chk("drain.ValidE", 64'(ValidE), 64'd0);

    // Stall then flush
    sh1 = '{rI(7'h10, 3'b010, 5'd9, OP), 64'hAB, 64'hCD,
            64'hCD, 4'b1000, 3'b010, 1'b1, 1'b0, 1'b0};
    xr  = '{rI(7'h00, 3'b100, 5'd4, OP), 64'h77, 64'h88,
            64'h88, 4'b0101, 3'b010, 1'b1, 1'b0, 1'b0};
    drive(sh1);
    @(negedge clk);
    popCheck();
    ReadyE = 1'b0;
    drive(xr);
    void'(q.pop_back());
    cntModel = ZbaCountE;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall.ReadyD", 64'(ReadyD), 64'd0);
      chk("stall.ValidE", 64'(ValidE), 64'd1);
      chk("stall.ALU", 64'(ALUControlE), 64'b1000);
      chk("stall.SrcAE", SrcAE, 64'hAB);
      chk("stall.RdE", 64'(RdE), 64'd9);
      chk("stall.cnt", 64'(ZbaCountE), 64'd5);
    end
    FlushE = 1'b1;
    @(negedge clk);
    chk("flushStall.ValidE", 64'(ValidE), 64'd0);
    chk("flushStall.cnt", 64'(ZbaCountE), 64'd5);
    ReadyE = 1'b1;
    InstrD = sh1.instr;
    @(negedge clk);
    chk("flushRdy.ValidE", 64'(ValidE), 64'd0);
    chk("flushRdy.cnt", 64'(ZbaCountE), 64'd5);
    chk("flushRdy.ALU", 64'(ALUControlE), 64'b1000);
    FlushE = 1'b0;
    ValidD = 1'b0;

    // Reset asserted mid-stall
    ad = '{iI(12'h005, 3'b000, 5'd6), 64'h3, 64'h0,
           64'h5, 4'b0000, 3'b010, 1'b1, 1'b0, 1'b0};
    @(negedge clk);
    drive(ad);
    void'(q.pop_back());
    @(negedge clk);
    ReadyE = 1'b0;
    chk("preRst.ValidE", 64'(ValidE), 64'd1);
    chk("preRst.SrcBE", SrcBE, 64'h5);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkReset("midStall");
    @(negedge clk);
    ValidD = 1'b0;
    ReadyE = 1'b1;
    rst_n = 1'b1;

    // Saturation: 17 back-to-back sh1add
    InstrD = sh1.instr;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      ValidD = 1'b1;
      if (i == 15) chk("sat15", 64'(ZbaCountE), 64'hF);
    end
    @(negedge clk);
    ValidD = 1'b0;
    chk("sat17", 64'(ZbaCountE), 64'hF);
    @(negedge clk);
    chk("satHold", 64'(ZbaCountE), 64'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
